// File: rtl/vsync_generator.sv
// -----------------------------------------------------------------------------
// vsync_generator
//
// Vertical timing stage fed by the frame-cycle counter. It turns the 20-bit
// frame-cycle count into registered vertical video signals: line index,
// active-low vertical sync, vertical active window and a once-per-frame start
// pulse. The block stays unlocked (outputs at reset values) until a count of 0
// is seen, then tracks lines with its own sub-line cycle counter.
//
// Optional feature macro: VSYNC_CHECK_EN
//   defined   -> count-discontinuity checker compiled in, SyncErr is sticky
//   undefined -> checker absent, SyncErr tied to 0
//
// Ports:
//   Clk          in   1   system clock (only clock)
//   Reset        in   1   synchronous, active-high reset
//   cntVertical  in  20   frame-cycle count from the upstream counter
//   Linea        out 10   current line index, 0..LINES_TOTAL-1
//   VSync        out  1   vertical sync, active low
//   vActive      out  1   high during visible lines
//   FrameStart   out  1   one-cycle pulse the cycle after count 0 is sampled
//   SyncErr      out  1   sticky count-discontinuity flag
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module vsync_generator #(
  parameter int CLKS_PER_LINE = 1600,
  parameter int LINES_ACTIVE  = 480,
  parameter int LINES_FP      = 10,
  parameter int LINES_SYNC    = 2,
  parameter int LINES_BP      = 33
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [19:0] cntVertical,
  output logic [9:0]  Linea,
  output logic        VSync,
  output logic        vActive,
  output logic        FrameStart,
  output logic        SyncErr
);

  localparam int LINES_TOTAL = LINES_ACTIVE + LINES_FP + LINES_SYNC + LINES_BP;
  localparam int SUB_W       = (CLKS_PER_LINE > 1) ? $clog2(CLKS_PER_LINE) : 1;

  localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(CLKS_PER_LINE - 1);
  localparam logic [9:0]       LINE_LAST  = 10'(LINES_TOTAL - 1);
  localparam logic [9:0]       LINE_FRONT = 10'(LINES_ACTIVE);
  localparam logic [9:0]       LINE_SYNC  = 10'(LINES_ACTIVE + LINES_FP);
  localparam logic [9:0]       LINE_BACK  = 10'(LINES_ACTIVE + LINES_FP + LINES_SYNC);

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_FRONT,
    ST_SYNC,
    ST_BACK
  } region_e;

  region_e          r_state;
  logic [SUB_W-1:0] r_sub;
  logic [9:0]       r_linea;
  logic             r_locked;
  logic             r_vsync;
  logic             r_vactive;
  logic             r_frame_start;

  logic             w_resync;
  logic             w_line_end;
  logic             w_line_sat;
  logic [9:0]       w_linea_nxt;

  assign w_resync    = (cntVertical == 20'd0);
  assign w_line_end  = (r_sub == SUB_LAST);
  // The upstream counter has one state more than a whole number of lines, so
  // the last line absorbs the extra cycle by holding at its final sub count.
  assign w_line_sat  = (r_linea == LINE_LAST);
  assign w_linea_nxt = r_linea + 10'd1;

  // Line tracking and region FSM. Decoded outputs are registered from the
  // state being entered, so they line up with Linea.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: non-blocking assignments make every register update from the
      // values present before the edge, independent of statement order.
      r_state       <= ST_ACTIVE;
      r_sub         <= '0;
      r_linea       <= '0;
      r_locked      <= 1'b0;
      r_vsync       <= 1'b1;
      r_vactive     <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_resync) begin
      // Count 0 locks the block and restarts the frame from any state.
      r_state       <= ST_ACTIVE;
      r_sub         <= '0;
      r_linea       <= '0;
      r_locked      <= 1'b1;
      r_vsync       <= 1'b1;
      r_vactive     <= 1'b1;
      r_frame_start <= 1'b1;
    end else if (r_locked) begin
      r_frame_start <= 1'b0;
      if (!w_line_end) begin
        r_sub <= r_sub + SUB_W'(1);
      end else if (!w_line_sat) begin
        r_sub   <= '0;
        r_linea <= w_linea_nxt;
        case (r_state)
          ST_ACTIVE: if (w_linea_nxt == LINE_FRONT) begin
            r_state   <= ST_FRONT;
            r_vactive <= 1'b0;
          end
          ST_FRONT: if (w_linea_nxt == LINE_SYNC) begin
            r_state <= ST_SYNC;
            r_vsync <= 1'b0;
          end
          ST_SYNC: if (w_linea_nxt == LINE_BACK) begin
            r_state <= ST_BACK;
            r_vsync <= 1'b1;
          end
          default: begin
            // Back porch runs until the next resync.
          end
        endcase
      end
    end
  end

  assign Linea      = r_linea;
  assign VSync      = r_vsync;
  assign vActive    = r_vactive;
  assign FrameStart = r_frame_start;

`ifdef VSYNC_CHECK_EN
  logic [19:0] r_prev;
  logic        r_sync_err;

  // A locked stream must either step by one or restart at 0; anything else
  // latches the error until Reset. The check uses the lock state from before
  // this sample, so the locking 0 itself is never compared.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_prev     <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_prev <= cntVertical;
      if (r_locked && !w_resync && (cntVertical != r_prev + 20'd1)) begin
        r_sync_err <= 1'b1;
      end
    end
  end

  assign SyncErr = r_sync_err;
`else
  assign SyncErr = 1'b0;
`endif

endmodule

// File: tb/tb_vsync_generator.sv
// -----------------------------------------------------------------------------
// tb_vsync_generator
//
// Self-checking bench for vsync_generator, built with reduced line timing so
// whole frames stay short. Every cycle is compared against a reference model
// that derives the outputs from elapsed cycles since the last count 0; a
// vector table and hand-written sequences cover reset, lock and region edges.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vsync_generator;

  localparam int CPL     = 8;
  localparam int LA      = 12;
  localparam int LF      = 3;
  localparam int LS      = 2;
  localparam int LB      = 4;
  localparam int LT      = LA + LF + LS + LB;
  localparam int CNT_MAX = CPL * LT;

`ifdef VSYNC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic [19:0] cntVertical;
  logic [9:0]  Linea;
  logic        VSync;
  logic        vActive;
  logic        FrameStart;
  logic        SyncErr;

  vsync_generator #(
    .CLKS_PER_LINE (CPL),
    .LINES_ACTIVE  (LA),
    .LINES_FP      (LF),
    .LINES_SYNC    (LS),
    .LINES_BP      (LB)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .cntVertical (cntVertical),
    .Linea       (Linea),
    .VSync       (VSync),
    .vActive     (vActive),
    .FrameStart  (FrameStart),
    .SyncErr     (SyncErr)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: outputs follow from how many cycles have elapsed since
  // the last sampled count 0, with the line index saturating at the last line.
  bit          m_locked = 1'b0;
  int          m_ph     = 0;
  bit          m_err    = 1'b0;
  logic [19:0] m_prev   = '0;
  logic [9:0]  e_linea;
  logic        e_vs, e_va, e_fs, e_err;

  task automatic model_update(input logic rst, input logic [19:0] cnt);
    int line;
    if (rst) begin
      m_locked = 1'b0;
      m_ph     = 0;
      m_err    = 1'b0;
    end else begin
      if (CHECK_EN && m_locked && cnt != 20'd0 && cnt != 20'(m_prev + 20'd1))
        m_err = 1'b1;
      if (cnt == 20'd0) begin
        m_locked = 1'b1;
        m_ph     = 0;
      end else if (m_locked) begin
        m_ph++;
      end
    end
    m_prev = cnt;
    e_fs   = !rst && (cnt == 20'd0);
    e_err  = m_err;
    if (m_locked) begin
      line = m_ph / CPL;
      if (line > LT - 1) line = LT - 1;
      e_linea = 10'(line);
      e_va    = (line < LA);
      e_vs    = !(line >= LA + LF && line < LA + LF + LS);
    end else begin
      e_linea = '0;
      e_va    = 1'b0;
      e_vs    = 1'b1;
    end
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic rst, input logic [19:0] cnt);
    @(negedge Clk);
    Reset       = rst;
    cntVertical = cnt;
    @(posedge Clk);
    #1;
    cyc++;
    model_update(rst, cnt);
    check("model", {18'd0, Linea, VSync, vActive, FrameStart, SyncErr},
          {18'd0, e_linea, e_vs, e_va, e_fs, e_err});
  endtask

  typedef struct {
    logic        rst;
    logic [19:0] cnt;
    logic [9:0]  linea;
    logic        vs;
    logic        va;
    logic        fs;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int pulses;
    int first_pulse;
    int gap;
    int last_line_len;
    int max_line;
    int vs_lows;
    logic [19:0] cnt;
    logic        rst;

    Reset       = 1'b1;
    cntVertical = 20'd0;

    // Reset, a stream starting mid-frame, lock on 0, first line change,
    // then Reset together with count 0 (Reset wins, block stays unlocked).
    tbl[0]  = '{1'b1, 20'd0,  10'd0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 20'd50, 10'd0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 20'd51, 10'd0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 20'd0,  10'd0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 20'd1,  10'd0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 20'd2,  10'd0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 20'd3,  10'd0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 20'd4,  10'd0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 20'd5,  10'd0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 20'd6,  10'd0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 20'd7,  10'd0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 20'd8,  10'd1, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 20'd0,  10'd0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 20'd1,  10'd0, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 20'd2,  10'd0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].cnt);
      check($sformatf("vec%0d", i), {22'd0, Linea, VSync, vActive, FrameStart},
            {22'd0, tbl[i].linea, tbl[i].vs, tbl[i].va, tbl[i].fs});
      check($sformatf("vec%0d_err", i), {31'd0, SyncErr}, 32'd0);
    end

    // Two full frames: pulse spacing, last-line length and region edges.
    step(1'b1, 20'd0);
    pulses      = 0;
    first_pulse = 0;
    gap         = 0;
    max_line    = 0;
    for (int f = 0; f < 2; f++) begin
      last_line_len = 0;
      for (int c = 0; c <= CNT_MAX; c++) begin
        step(1'b0, 20'(c));
        if (FrameStart) begin
          if (pulses == 0) first_pulse = cyc;
          else gap = cyc - first_pulse;
          pulses++;
        end
        if (int'(Linea) > max_line) max_line = int'(Linea);
        if (int'(Linea) == LT - 1) last_line_len++;
        if (c == LA * CPL - 1)             check("vactive_before_fall", {31'd0, vActive}, 32'd1);
        if (c == LA * CPL)                 check("vactive_fall",        {31'd0, vActive}, 32'd0);
        if (c == (LA + LF) * CPL - 1)      check("vsync_before_fall",   {31'd0, VSync},   32'd1);
        if (c == (LA + LF) * CPL)          check("vsync_fall",          {31'd0, VSync},   32'd0);
        if (c == (LA + LF + LS) * CPL - 1) check("vsync_before_rise",   {31'd0, VSync},   32'd0);
        if (c == (LA + LF + LS) * CPL)     check("vsync_rise",          {31'd0, VSync},   32'd1);
      end
      check("last_line_len", 32'(last_line_len), 32'(CPL + 1));
    end
    check("frame_pulses", 32'(pulses), 32'd2);
    check("frame_gap", 32'(gap), 32'(CNT_MAX + 1));
    check("max_line", 32'(max_line), 32'(LT - 1));
    check("frame_err", {31'd0, SyncErr}, 32'd0);

    // Discontinuity 10 -> 30: sticky through another frame, cleared by Reset.
    step(1'b1, 20'd0);
    for (int c = 0; c <= 10; c++) step(1'b0, 20'(c));
    step(1'b0, 20'd30);
    check("err_jump", {31'd0, SyncErr}, {31'd0, CHECK_EN});
    for (int c = 31; c <= CNT_MAX; c++) step(1'b0, 20'(c));
    for (int c = 0; c <= CNT_MAX; c++) step(1'b0, 20'(c));
    check("err_sticky", {31'd0, SyncErr}, {31'd0, CHECK_EN});
    step(1'b1, 20'd0);
    check("err_cleared", {31'd0, SyncErr}, 32'd0);

    // Reset during sync: VSync released next cycle, no sync low until the
    // following frame's sync region.
    for (int c = 0; c < (LA + LF) * CPL + 5; c++) step(1'b0, 20'(c));
    check("vsync_low_pre_reset", {31'd0, VSync}, 32'd0);
    step(1'b1, 20'((LA + LF) * CPL + 5));
    check("vsync_after_reset", {31'd0, VSync}, 32'd1);
    vs_lows = 0;
    for (int c = (LA + LF) * CPL + 6; c <= CNT_MAX; c++) begin
      step(1'b0, 20'(c));
      if (!VSync) vs_lows++;
    end
    for (int c = 0; c < (LA + LF) * CPL; c++) begin
      step(1'b0, 20'(c));
      if (!VSync) vs_lows++;
    end
    check("no_vsync_after_reset", 32'(vs_lows), 32'd0);
    step(1'b0, 20'((LA + LF) * CPL));
    check("vsync_next_frame", {31'd0, VSync}, 32'd0);

    // Random stream: mostly continuous, with jumps, resyncs and resets.
    step(1'b1, 20'd0);
    cnt = 20'd0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r   = int'($urandom_range(0, 999));
      rst = 1'b0;
      if (r < 5)       rst = 1'b1;
      else if (r < 15) cnt = 20'd0;
      else if (r < 30) cnt = 20'($urandom_range(0, CNT_MAX));
      else             cnt = (int'(cnt) >= CNT_MAX) ? 20'd0 : cnt + 20'd1;
      step(rst, cnt);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vsync_generator.md
# vsync_generator

Vertical timing stage directly downstream of the vertical frame counter (`contadorvertical`). It consumes the 20-bit frame-cycle count (0..840000, one step per `Clk`) and turns it into the registered vertical video signals: line index, active-low vertical sync, vertical active window and a once-per-frame start pulse. A sticky checker flags count discontinuities. Its outputs feed the pixel/colour logic and the VGA connector.

## Interface
- `CLKS_PER_LINE`, 1600: `Clk` cycles per video line.
- `LINES_ACTIVE`, 480: visible lines.
- `LINES_FP`, 10: front-porch lines.
- `LINES_SYNC`, 2: sync-pulse lines.
- `LINES_BP`, 33: back-porch lines. Total lines `LINES_TOTAL` = sum = 525.

Ports:
- `Clk`  in  1  system clock; the only clock.
- `Reset`  in  1  synchronous, active-high reset.
- `cntVertical`  in  20  frame-cycle count from the upstream counter.
- `Linea`  out  10  current line index, 0..524.
- `VSync`  out  1  vertical sync, active low.
- `vActive`  out  1  high during lines 0..479.
- `FrameStart`  out  1  one-cycle pulse at frame start.
- `SyncErr`  out  1  sticky count-discontinuity flag.

## Operation
- Internal `sub` counter (11 bits, 0..CLKS_PER_LINE-1) and line counter `Linea`; both registered.
- Lock: after reset the block is unlocked; all outputs hold reset values until `cntVertical == 0` is sampled. That sample sets locked.
- Per cycle, while locked or locking:
  - `cntVertical == 0`: `sub <= 0`, `Linea <= 0`, `FrameStart <= 1` (resync has priority over everything else).
  - else if `sub == CLKS_PER_LINE-1` and `Linea != LINES_TOTAL-1`: `sub <= 0`, `Linea <= Linea+1`.
  - else if `sub == CLKS_PER_LINE-1` and `Linea == LINES_TOTAL-1`: hold both (saturate). The upstream counter has 840001 states, so line 524 lasts 1601 cycles; this is required behaviour, not an error.
  - else `sub <= sub+1`. `FrameStart` is 0 except on the resync cycle.
- Region FSM, states ACTIVE, FRONT, SYNC, BACK, advancing on line increments:
  - ACTIVE → FRONT when `Linea` goes to 480; FRONT → SYNC at 490; SYNC → BACK at 492; BACK → ACTIVE on resync (line 0).
  - Resync from any state forces ACTIVE.
- Decoded outputs are registered from the next state: `VSync = 0` only in SYNC; `vActive = 1` only in ACTIVE.
- Checker: with `prev` = previous sampled count, set `SyncErr` when locked and `cntVertical != prev+1` and `cntVertical != 0`. It stays set until `Reset`. Resync still occurs on an out-of-order 0.

## Timing
- Reset values: `Linea` 0, `VSync` 1, `vActive` 0, `FrameStart` 0, `SyncErr` 0, FSM ACTIVE, unlocked.
- Latency: one cycle. A `cntVertical` value sampled at edge n is reflected on outputs after edge n. `FrameStart` is high the cycle after the upstream counter shows 0.
- Line k (k < 524) spans counts k·1600 .. k·1600+1599.
- `VSync` is low for counts 784000..787199 (3200 cycles); outputs lag by one cycle.
- `Reset` mid-frame returns all state to reset values and unlocks the block. Output resumes only at the next count 0.
- Both `Reset` and resync in the same cycle: `Reset` wins.

## Configuration
- `VSYNC_CHECK_EN` defined: `prev` register and discontinuity checker are compiled in; `SyncErr` behaves as above.
- Not defined: checker logic is absent and `SyncErr` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then drive counts 0..840000 twice: `FrameStart` pulses exactly twice, 840001 cycles apart. `Linea` runs 0..524, with line 524 lasting 1601 cycles. `SyncErr` stays 0.
- Check region edges: `vActive` falls one cycle after count 768000. `VSync` falls one cycle after 784000 and rises one cycle after 787200.
- Start the stream at count 5000 after reset: outputs hold reset values (`VSync` 1, `Linea` 0) until count 0 is sampled, then lock.
- With the macro defined, jump the count from 100 to 300: `SyncErr` = 1 one cycle later and stays 1 through subsequent frames until `Reset`. Without the macro, `SyncErr` stays 0.
- Assert `Reset` at count 785000 (during sync): `VSync` returns to 1 the cycle after. There is no sync low until the next frame's count 784000.
- Assert `Reset` in the same cycle as count 0 is sampled: no `FrameStart` pulse, and the block is unlocked afterwards.
